// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: divider sequencer states and latency.
package cpu_defs_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 1;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on magnitude operands.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    // rem < dvsr before the shift, so the shifted value needs one extra bit
    // for the compare, while the difference always fits back into WIDTH bits.
    assign rem_sh = {rem_i, quo_i[WIDTH-1]};
    assign diff   = rem_sh[WIDTH-1:0] - dvsr_i;

    always_comb begin
        if (rem_sh >= {1'b0, dvsr_i}) begin
            rem_o = diff;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Iterative DIV/DIVU sequencer: latches operands, runs WIDTH restoring steps,
// applies sign fixup and stalls the pipeline while busy.
module div_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             result_valid_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             valid_q, valid_d;
    logic             stall;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] step_rem, step_quo;

    assign a_neg = signed_i & a_i[WIDTH-1];
    assign b_neg = signed_i & b_i[WIDTH-1];
    assign a_abs = a_neg ? -a_i : a_i;
    assign b_abs = b_neg ? -b_i : b_i;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        valid_d   = 1'b0;
        stall     = 1'b0;

        unique case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    stall     = 1'b1;
                    state_d   = DIV_BUSY;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = a_abs;
                    dvsr_d    = b_abs;
                    neg_quo_d = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & signed_i;
                    neg_rem_d = a_neg;
                end
            end
            DIV_BUSY: begin
                stall = 1'b1;
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                // A zero divisor reports all-ones regardless of sign; the
                // remainder fixup already reproduces the raw dividend.
                state_d = DIV_IDLE;
                valid_d = 1'b1;
                hi_d    = neg_rem_q ? -rem_q : rem_q;
                lo_d    = (dvsr_q == '0) ? '1 : (neg_quo_q ? -quo_q : quo_q);
            end
            default: state_d = DIV_IDLE;
        endcase

        if (cancel_i) begin
            state_d = DIV_IDLE;
            stall   = 1'b0;
            valid_d = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            valid_q   <= valid_d;
        end
    end

    assign stall_o        = stall;
    assign result_valid_o = valid_q;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed fixup, divide-by-zero,
// cancel, back-to-back and reset behaviour against hand-computed results.
module tb_div_ctrl;
    import cpu_defs_pkg::*;

    localparam int W = DIV_WIDTH;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start_i;
    logic         signed_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cancel_i;
    logic         stall_o;
    logic         result_valid_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int n_checks = 0;
    int n_pass   = 0;

    div_ctrl #(.WIDTH(W)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start_i        (start_i),
        .signed_i       (signed_i),
        .a_i            (a_i),
        .b_i            (b_i),
        .cancel_i       (cancel_i),
        .stall_o        (stall_o),
        .result_valid_o (result_valid_o),
        .hi_o           (hi_o),
        .lo_o           (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle n is the n-th cycle after the start cycle; results land in cycle 34.
    task automatic run_div(input string tag, input logic sgn,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
        int           stall_cnt = 0;
        int           valid_cnt = 0;
        int           valid_at  = -1;
        logic [W-1:0] lo_s = '0;
        logic [W-1:0] hi_s = '0;
        for (int n = 0; n < DIV_LATENCY + 5; n++) begin
            start_i  = (n == 0);
            signed_i = sgn;
            a_i      = (n == 0) ? a : $urandom;
            b_i      = (n == 0) ? b : $urandom;
            #1;
            if (stall_o) stall_cnt++;
            if (result_valid_o) begin
                valid_cnt++;
                valid_at = n;
                lo_s     = lo_o;
                hi_s     = hi_o;
            end
            tick();
        end
        start_i = 1'b0;
        check({tag, " stall cycles"}, W'(stall_cnt), W'(DIV_LATENCY));
        check({tag, " valid count"}, W'(valid_cnt), W'(1));
        check({tag, " valid cycle"}, W'(valid_at), W'(DIV_LATENCY + 1));
        check({tag, " lo"}, lo_s, exp_lo);
        check({tag, " hi"}, hi_s, exp_hi);
    endtask

    initial begin
        int           vcnt;
        int           vat [2];
        logic [W-1:0] vlo [2];
        logic [W-1:0] vhi [2];
        logic         s_pre, s_can, s_nxt, s33, s34;
        int           stall_cnt;

        resetn   = 1'b0;
        start_i  = 1'b0;
        signed_i = 1'b0;
        a_i      = '0;
        b_i      = '0;
        cancel_i = 1'b0;
        tick();
        tick();
        check("reset stall", W'(stall_o), W'(0));
        check("reset valid", W'(result_valid_o), W'(0));
        check("reset hi", hi_o, '0);
        check("reset lo", lo_o, '0);
        resetn = 1'b1;
        tick();

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("div intmin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("divu big/big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE);
        run_div("div -9/0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7);
        run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

        // Cancel in BUSY cycle 10.
        vcnt  = 0;
        s_pre = 1'b0;
        s_can = 1'b1;
        s_nxt = 1'b1;
        for (int n = 0; n < 46; n++) begin
            start_i  = (n == 0);
            signed_i = 1'b0;
            cancel_i = (n == 10);
            a_i      = 32'd1000;
            b_i      = 32'd3;
            #1;
            if (n == 9)  s_pre = stall_o;
            if (n == 10) s_can = stall_o;
            if (n == 11) s_nxt = stall_o;
            if (result_valid_o) vcnt++;
            tick();
        end
        cancel_i = 1'b0;
        check("cancel busy before", W'(s_pre), W'(1));
        check("cancel stall drop", W'(s_can), W'(0));
        check("cancel idle after", W'(s_nxt), W'(0));
        check("cancel no valid", W'(vcnt), W'(0));
        check("cancel lo kept", lo_o, 32'hFFFF_FFFF);
        check("cancel hi kept", hi_o, 32'd5);
        run_div("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Cancel in DONE suppresses the write.
        vcnt = 0;
        for (int n = 0; n < DIV_LATENCY + 5; n++) begin
            start_i  = (n == 0);
            cancel_i = (n == DIV_LATENCY);
            a_i      = 32'd100;
            b_i      = 32'd7;
            #1;
            if (result_valid_o) vcnt++;
            tick();
        end
        cancel_i = 1'b0;
        check("done-cancel no valid", W'(vcnt), W'(0));
        check("done-cancel lo kept", lo_o, 32'd3);
        check("done-cancel hi kept", hi_o, 32'd0);

        // Back-to-back with start held through DONE.
        vcnt = 0;
        vat  = '{-1, -1};
        vlo  = '{'0, '0};
        vhi  = '{'0, '0};
        s33  = 1'b1;
        s34  = 1'b0;
        for (int n = 0; n < 2 * (DIV_LATENCY + 1) + 4; n++) begin
            start_i  = (n <= DIV_LATENCY + 1);
            signed_i = (n > DIV_LATENCY);
            a_i      = (n > DIV_LATENCY) ? 32'hFFFF_FFF9 : 32'd100;
            b_i      = (n > DIV_LATENCY) ? 32'd2 : 32'd7;
            #1;
            if (n == DIV_LATENCY)     s33 = stall_o;
            if (n == DIV_LATENCY + 1) s34 = stall_o;
            if (result_valid_o) begin
                if (vcnt < 2) begin
                    vat[vcnt] = n;
                    vlo[vcnt] = lo_o;
                    vhi[vcnt] = hi_o;
                end
                vcnt++;
            end
            tick();
        end
        start_i = 1'b0;
        check("b2b done no stall", W'(s33), W'(0));
        check("b2b second start", W'(s34), W'(1));
        check("b2b valid count", W'(vcnt), W'(2));
        check("b2b first valid cycle", W'(vat[0]), W'(DIV_LATENCY + 1));
        check("b2b second valid cycle", W'(vat[1]), W'(2 * (DIV_LATENCY + 1)));
        check("b2b first lo", vlo[0], 32'd14);
        check("b2b first hi", vhi[0], 32'd2);
        check("b2b second lo", vlo[1], 32'hFFFF_FFFD);
        check("b2b second hi", vhi[1], 32'hFFFF_FFFF);

        // Reset mid-BUSY.
        for (int n = 0; n < 10; n++) begin
            start_i  = (n == 0);
            signed_i = 1'b0;
            a_i      = 32'd100;
            b_i      = 32'd7;
            tick();
        end
        start_i = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        check("midreset stall", W'(stall_o), W'(0));
        check("midreset valid", W'(result_valid_o), W'(0));
        check("midreset hi", hi_o, '0);
        check("midreset lo", lo_o, '0);
        tick();
        #2;
        resetn = 1'b1;
        tick();
        stall_cnt = 0;
        for (int n = 0; n < 5; n++) begin
            #1;
            if (stall_o) stall_cnt++;
            tick();
        end
        check("post-reset stall", W'(stall_cnt), W'(0));
        check("post-reset lo", lo_o, '0);
        run_div("post-reset divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer for the iterative 32-bit integer divider used by DIV/DIVU in the execute stage. It accepts operands when a divide instruction sits in E and raises `stall_o`, which is wired to `div_stallE` of the hazard unit. It runs one restoring shift-subtract step per cycle and returns HI (remainder) and LO (quotient). On an exception flush it aborts without writing a result.

## Interface
- `WIDTH`, 32, operand and result width; the counter is `$clog2(WIDTH)` bits.
- `clk`  in  1  pipeline clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  a DIV/DIVU instruction is valid in E this cycle.
- `signed_i`  in  1  1 = DIV (signed), 0 = DIVU.
- `a_i`  in  WIDTH  dividend (rs value after E forwarding).
- `b_i`  in  WIDTH  divisor (rt value after E forwarding).
- `cancel_i`  in  1  exception flush (`is_exceptM`); kills any operation in flight.
- `stall_o`  out  1  hold F/D/E and bubble M; drives `div_stallE`.
- `result_valid_o`  out  1  one-cycle pulse; `hi_o`/`lo_o` are new this cycle.
- `hi_o`  out  WIDTH  remainder, registered; holds until the next completion.
- `lo_o`  out  WIDTH  quotient, registered; holds until the next completion.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - `start_i & !cancel_i` → latch |a|, |b|, quotient sign (a[msb]^b[msb])&signed_i, remainder sign a[msb]&signed_i.
  - Clear the partial remainder and counter. Go to BUSY.
- **BUSY:**
  - Each cycle: shift {rem, quo} left by 1. If rem ≥ |b|, subtract |b| and set the quotient LSB.
  - The counter increments. When counter == WIDTH-1, the step completes and the state goes to DONE.
- **DONE:**
  - Apply sign fixup (two's-complement negate of each magnitude where its sign bit is set) and register the results into `hi_o`/`lo_o`.
  - Assert `result_valid_o` and go to IDLE.
  - `start_i` is ignored in DONE, because the same instruction is leaving E.
- **stall_o** = !cancel_i & ((IDLE & start_i) | BUSY). It is combinational and low in DONE, so E advances exactly once per divide.
- **cancel_i** in any state → next state IDLE.
  - No `result_valid_o` is produced; `hi_o`/`lo_o` are unchanged.
  - `cancel_i` in DONE also suppresses the result write.
- **Divide by zero:** the loop runs normally and yields lo = all-ones (magnitude), hi = |a|. The result is fixed as lo = 0xFFFFFFFF and hi = a_i (raw) for both signednesses. No trap is raised.
- **INT_MIN / -1 (signed):** lo = 0x80000000, hi = 0.
- **Reset:** state IDLE, counter 0, `hi_o` = `lo_o` = 0, `result_valid_o` = 0, `stall_o` = 0. Reset mid-BUSY discards the operation.

## Timing
- Cycle 0: IDLE with `start_i` = 1. `stall_o` = 1 and operands are latched.
- Cycles 1..WIDTH: BUSY, `stall_o` = 1.
- Cycle WIDTH+1: DONE, `stall_o` = 0.
- Results: `hi_o`/`lo_o` and `result_valid_o` appear in the cycle after DONE (cycle WIDTH+2), registered.
- Total stall: WIDTH+1 = 33 cycles.
- A new `start_i` is accepted no earlier than the cycle after DONE.
- Back-to-back divides: the second starts in cycle WIDTH+2, with no idle gap beyond DONE.
- Operands are sampled only in the IDLE start cycle. Later changes of `a_i`/`b_i` (e.g. forwarding updates) are ignored.
- `cancel_i` takes effect combinationally on `stall_o` and in registered form on state.

## Structure
- Shared package `cpu_defs_pkg` holds:
  - enum `div_state_t` {DIV_IDLE, DIV_BUSY, DIV_DONE};
  - constant `DIV_LATENCY` = WIDTH+1, also used by the hazard documentation.
- Sub-module `div_step`: one combinational restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
- `div_ctrl` holds the FSM, counter, operand and sign registers, and the fixup and output registers.

## Test plan
- DIVU 100/7 → `stall_o` high for exactly 33 cycles. Then lo = 14, hi = 2, and `result_valid_o` pulses once.
- DIV -7/2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 7/-2 → lo = 0xFFFFFFFD, hi = 1.
- DIV 0x80000000/0xFFFFFFFF → lo = 0x80000000, hi = 0. DIVU 5/0 → lo = 0xFFFFFFFF, hi = 5.
- Start a divide, then assert `cancel_i` in BUSY cycle 10:
  - `stall_o` drops in the same cycle and the state is IDLE next cycle;
  - there is no valid pulse and `hi_o`/`lo_o` keep their previous values;
  - a following DIVU 9/3 gives lo = 3, hi = 0.
- Back-to-back divides with `start_i` held through DONE:
  - DONE does not restart the divider;
  - the second divide starts one cycle later;
  - each divide produces exactly one valid pulse.
- Assert `resetn` low mid-BUSY → all outputs go to 0 immediately. After release, with `start_i` low, `stall_o` stays 0.
